// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path:
// FSM states, frame constants and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = 8;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;

    function automatic logic parity_of(
        input logic [DATA_BITS-1:0] d,
        input logic                 odd
    );
        return odd ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the transmitter.
// The producer drives valid/byte, the transmitter drives ready.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_byte,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_byte,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_piso.sv
// Parallel-in/serial-out shifter for the transmit frame.
// sout is the bit that bit 0 will hold after the coming edge.
module tx_piso
    import uart_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATA_BITS-1:0] din,
    output logic                 sout
);

    logic [DATA_BITS-1:0] q;
    logic [DATA_BITS-1:0] q_n;

    // Load wins over shift; shifting moves the next data bit into bit 0.
    always_comb begin
        q_n = q;
        if (load) begin
            q_n = din;
        end else if (shift) begin
            q_n = {1'b0, q[DATA_BITS-1:1]};
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_n;
        end
    end

    assign sout = q_n[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte hold register, frame FSM and a
// registered serial line driven from the next-state decode.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic clk,
    input  logic reset,
    uart_tx_if.slave bus,
    output logic tx_data_out,
    output logic tx_busy,
    output logic tx_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    state_t               state;
    state_t               state_n;
    logic [TW-1:0]        timer;
    logic [2:0]           idx;
    logic                 par;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_valid;
    logic                 load;
    logic                 shift;
    logic                 bit_last;
    logic                 line_n;
    logic                 piso_bit;

    assign bit_last     = (timer == T_LAST);
    assign bus.tx_ready = ~hold_valid;
    assign tx_busy      = (state != IDLE);

    tx_piso u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (hold),
        .sout  (piso_bit)
    );

    // Next state, shifter control and the line value for the next cycle.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        tx_done = 1'b0;
        line_n  = STOP_LVL;
        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    load    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_last) state_n = DATA;
            end
            DATA: begin
                if (bit_last) begin
                    shift = 1'b1;
                    if (idx == 3'(DATA_BITS - 1)) state_n = PARITY;
                end
            end
            PARITY: begin
                if (bit_last) state_n = STOP;
            end
            STOP: begin
                if (bit_last) begin
                    tx_done = 1'b1;
                    if (hold_valid) begin
                        load    = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
        unique case (state_n)
            IDLE:   line_n = STOP_LVL;
            START:  line_n = START_LVL;
            DATA:   line_n = piso_bit;
            PARITY: line_n = par;
            STOP:   line_n = STOP_LVL;
        endcase
    end

    // FSM state and the glitch-free registered line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_data_out <= STOP_LVL;
        end else begin
            state       <= state_n;
            tx_data_out <= line_n;
        end
    end

    // Bit timer and data bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
            idx   <= '0;
        end else begin
            if (load || state == IDLE || bit_last) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (load) begin
                idx <= '0;
            end else if (state == DATA && bit_last) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Hold register: filled by the handshake, freed when the FSM loads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            par        <= 1'b0;
        end else begin
            if (load) begin
                hold_valid <= 1'b0;
                par        <= parity_of(hold, PARITY_ODD != 0);
            end else if (bus.tx_valid && !hold_valid) begin
                hold       <= bus.tx_byte;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-position model is
// compared every cycle, plus directed frames with literal expectations.
module tb_uart_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_if ia ();
    uart_tx_if ib ();

    logic a_line, a_busy, a_done;
    logic b_line, b_busy, b_done;

    uart_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) ua (
        .clk         (clk),
        .reset       (reset),
        .bus         (ia.slave),
        .tx_data_out (a_line),
        .tx_busy     (a_busy),
        .tx_done     (a_done)
    );

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) ub (
        .clk         (clk),
        .reset       (reset),
        .bus         (ib.slave),
        .tx_data_out (b_line),
        .tx_busy     (b_busy),
        .tx_done     (b_done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 1'b0;
    int cyc    = 0;

    int cpb [2] = '{1, 4};
    int odd [2] = '{0, 1};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame bit at position pos (0..10) for byte b.
    function automatic logic fbit(input logic [7:0] b, input int od,
                                  input int pos);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == 9) return (od != 0) ? logic'(1 - ones % 2)
                                       : logic'(ones % 2);
        return 1'b1;
    endfunction

    bit         m_act [2];
    bit         m_hv  [2];
    int         m_fc  [2];
    logic [7:0] m_byte[2];
    logic [7:0] m_hold[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Model: a frame is a run of 11*cpb cycles; one byte may wait.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_act[c] <= 1'b0;
                m_hv[c]  <= 1'b0;
                m_fc[c]  <= 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic       v;
                logic [7:0] d;
                bit         act_n, hv_n;
                int         fc_n;
                logic [7:0] byte_n, hold_n;
                v      = (c == 0) ? ia.tx_valid : ib.tx_valid;
                d      = (c == 0) ? ia.tx_byte : ib.tx_byte;
                act_n  = m_act[c];
                hv_n   = m_hv[c];
                fc_n   = m_fc[c];
                byte_n = m_byte[c];
                hold_n = m_hold[c];
                if (!m_act[c]) begin
                    if (m_hv[c]) begin
                        act_n = 1'b1; fc_n = 0;
                        byte_n = m_hold[c]; hv_n = 1'b0;
                    end
                end else if (m_fc[c] == 11 * cpb[c] - 1) begin
                    if (m_hv[c]) begin
                        fc_n = 0; byte_n = m_hold[c]; hv_n = 1'b0;
                    end else begin
                        act_n = 1'b0;
                    end
                end else begin
                    fc_n = m_fc[c] + 1;
                end
                if (v && !m_hv[c]) begin
                    hold_n = d; hv_n = 1'b1;
                end
                m_act[c]  <= act_n;
                m_hv[c]   <= hv_n;
                m_fc[c]   <= fc_n;
                m_byte[c] <= byte_n;
                m_hold[c] <= hold_n;
            end
        end
    end

    // Every-cycle comparison of both transmitters against the model.
    always @(negedge clk) begin
        if (run) begin
            for (int c = 0; c < 2; c++) begin
                logic el, ed;
                el = m_act[c] ? fbit(m_byte[c], odd[c], m_fc[c] / cpb[c])
                              : 1'b1;
                ed = m_act[c] && (m_fc[c] == 11 * cpb[c] - 1);
                chk($sformatf("ch%0d line", c),
                    (c == 0) ? a_line : b_line, el);
                chk($sformatf("ch%0d busy", c),
                    (c == 0) ? a_busy : b_busy, m_act[c]);
                chk($sformatf("ch%0d done", c),
                    (c == 0) ? a_done : b_done, ed);
                chk($sformatf("ch%0d ready", c),
                    (c == 0) ? ia.tx_ready : ib.tx_ready, !m_hv[c]);
            end
        end
    end

    task automatic drive(input int c, input logic v, input logic [7:0] b);
        if (c == 0) begin
            ia.tx_valid = v; ia.tx_byte = b;
        end else begin
            ib.tx_valid = v; ib.tx_byte = b;
        end
    endtask

    function automatic logic rdy(input int c);
        return (c == 0) ? ia.tx_ready : ib.tx_ready;
    endfunction

    // Present a byte and wait (bounded) for the handshake edge.
    task automatic send(input int c, input logic [7:0] b, input bit keep,
                        output int t_acc);
        t_acc = -1;
        @(negedge clk);
        drive(c, 1'b1, b);
        for (int k = 0; k < 300; k++) begin
            if (rdy(c)) begin
                @(posedge clk);
                t_acc = cyc;
                @(negedge clk);
                if (!keep) drive(c, 1'b0, b);
                return;
            end
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL send timeout ch%0d byte %0h", c, b);
        drive(c, 1'b0, b);
    endtask

    task automatic capture(input int c, input int n,
                           output logic [63:0] ln, output logic [63:0] dn,
                           output int bc);
        ln = '0; dn = '0; bc = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ln[k] = (c == 0) ? a_line : b_line;
            dn[k] = (c == 0) ? a_done : b_done;
            bc += int'((c == 0) ? a_busy : b_busy);
        end
    endtask

    function automatic logic [10:0] bits4(input logic [63:0] ln);
        logic [10:0] r;
        for (int k = 0; k < 11; k++) r[k] = ln[4*k+1];
        return r;
    endfunction

    logic [63:0] ln, dn;
    int          bc, t1, t2, t3;
    logic [7:0]  vec [4] = '{8'h00, 8'hFF, 8'h5A, 8'h80};

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset line", a_line, 1'b1);
        chk("reset ready", ia.tx_ready, 1'b1);
        chk("reset busy", b_busy, 1'b0);
        chk("reset done", b_done, 1'b0);
        reset = 1'b0;
        run   = 1'b1;

        send(0, 8'hA5, 1'b0, t1);
        capture(0, 12, ln, dn, bc);
        chk("a5 frame", ln[10:0], 11'b10101001010);
        chk("a5 done", dn[11:0], 12'b0100_0000_0000);
        chk("a5 idle", ln[11], 1'b1);
        chk("a5 busy cycles", bc, 11);

        send(1, 8'h00, 1'b0, t1);
        capture(1, 44, ln, dn, bc);
        chk("odd par 00", ln[37], 1'b1);
        send(1, 8'h01, 1'b0, t1);
        capture(1, 44, ln, dn, bc);
        chk("odd par 01", ln[37], 1'b0);

        send(1, 8'h3C, 1'b0, t1);
        capture(1, 48, ln, dn, bc);
        chk("3c bits", bits4(ln), 11'b11001111000);
        chk("3c busy cycles", bc, 44);
        chk("3c done", dn[47:0], 48'h080000000000);

        send(0, 8'h11, 1'b1, t1);
        send(0, 8'h22, 1'b1, t2);
        send(0, 8'h33, 1'b0, t3);
        chk("queue second", t2 - t1, 2);
        chk("queue third", t3 - t1, 13);
        capture(0, 25, ln, dn, bc);

        foreach (vec[i]) begin
            send(0, vec[i], 1'b0, t1);
            capture(0, 12, ln, dn, bc);
            chk($sformatf("rx start %0h", vec[i]), ln[0], 1'b0);
            chk($sformatf("rx data %0h", vec[i]), ln[8:1], vec[i]);
            chk($sformatf("rx parity err %0h", vec[i]), ^ln[9:1], 1'b0);
            chk($sformatf("rx stop %0h", vec[i]), ln[10], 1'b1);
        end

        send(1, 8'h55, 1'b0, t1);
        send(1, 8'h66, 1'b0, t2);
        repeat (16) @(negedge clk);
        chk("pre-reset line", b_line, 1'b0);
        chk("pre-reset busy", b_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid reset line", b_line, 1'b1);
        chk("mid reset ready", ib.tx_ready, 1'b1);
        chk("mid reset done", b_done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        capture(1, 10, ln, dn, bc);
        chk("post reset idle", ln[9:0], 10'h3FF);
        chk("post reset no done", dn[9:0], 10'h000);
        send(1, 8'h7E, 1'b0, t1);
        capture(1, 48, ln, dn, bc);
        chk("7e bits", bits4(ln), 11'b11011111100);
        chk("7e busy cycles", bc, 44);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
